// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB3 master
//
// Purpose: FSM state encoding, default bus widths, the response record
// used by the master and by bench monitors, and the wait-counter width rule.
// Ports: none (package).
package apb_pkg;

  localparam int APB_ADDR_W         = 32;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // Width of a counter that must hold 0..timeout_cycles; never below 1 bit
  // so a disabled timeout still yields a legal vector.
  function automatic int apb_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating wait-state counter with expire flag
//
// Purpose: counts ACCESS cycles spent waiting on the completer and flags
// expiry once the count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables
// expiry entirely.
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   load_i    in   clear the count (takes priority over inc_i)
//   inc_i     in   advance the count by one, saturating at the limit
//   expire_o  out  count has reached TIMEOUT_CYCLES
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int              CNT_W     = apb_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-requester APB3 master with wait-state timeout
//
// Purpose: converts a valid/ready command stream into APB3 transfers and
// returns one registered response per accepted command, in order.
// Ports:
//   pclk, preset                  clock / async active-high reset
//   cmd_valid, cmd_ready          command handshake (cmd_ready combinational)
//   cmd_write, cmd_addr, cmd_wdata command fields
//   rsp_valid                     one-cycle response pulse
//   rsp_rdata, rsp_err, rsp_timeout response fields
//   psel, penable, pwrite, paddr, pwdata  APB requester outputs (registered)
//   pready, pslverr, prdata       APB completer inputs, used only in ACCESS
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        state_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  logic timer_load;
  logic timer_inc;
  logic timer_expire;

  // SETUP always precedes ACCESS, so clearing there restarts the count on
  // every ACCESS entry, including back-to-back transfers.
  assign timer_load = (state_q == SETUP);
  assign timer_inc  = (state_q == ACCESS) && !pready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i   (pclk),
    .rst_i   (preset),
    .load_i  (timer_load),
    .inc_i   (timer_inc),
    .expire_o(timer_expire)
  );

  // In ACCESS the next command can only be taken on the completing edge,
  // hence the direct path from pready. A timeout never accepts.
  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      IDLE:    cmd_ready = !preset;
      ACCESS:  cmd_ready = pready;
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q   <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= cmd_write;
            paddr_q   <= cmd_addr;
            // Reads leave pwdata at its previous value.
            if (cmd_write) pwdata_q <= cmd_wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            penable_q     <= 1'b0;
            if (cmd_valid) begin
              // Back-to-back: psel stays high into the next SETUP.
              state_q  <= SETUP;
              pwrite_q <= cmd_write;
              paddr_q  <= cmd_addr;
              if (cmd_write) pwdata_q <= cmd_wdata;
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end else if (timer_expire) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;
  import apb_pkg::*;

  localparam int T = 8;

  typedef struct {
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } cfg_t;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } bus_t;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] last_wdata = '0;

  cfg_t     cfg_q[$];
  cfg_t     cur;
  bus_t     bus_q[$];
  bus_t     acc_q[$];
  int       acc_edge_q[$];
  apb_rsp_t rsp_q[$];
  int       rsp_edge_q[$];
  int       acc_cnt = 0;
  int       psel_cnt, pen_cnt, rspv_cnt, psel_rise;
  logic     psel_prev = 1'b0;
  logic [3:0] pen_hist;

  apb_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc = cyc + 1;

  // Completer model plus passive monitor. The completer answers each
  // transfer after cur.waits wait states and drives noise outside ACCESS.
  always begin
    @(negedge pclk);
    if (psel && penable) begin
      if (acc_cnt == 0) begin
        if (cfg_q.size() > 0) cur = cfg_q.pop_front();
        else begin cur.waits = 0; cur.err = 1'b0; cur.rdata = '0; end
        bus_q.push_back('{w: pwrite, a: paddr, d: pwdata});
      end
      if (acc_cnt == cur.waits) begin
        pready = 1'b1; pslverr = cur.err; prdata = cur.rdata;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    end
    #1;
    if (!preset) begin
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back('{w: cmd_write, a: cmd_addr, d: cmd_wdata});
        acc_edge_q.push_back(cyc + 1);
      end
      if (rsp_valid) begin
        rsp_q.push_back('{rdata: rsp_rdata, err: rsp_err, timeout: rsp_timeout});
        rsp_edge_q.push_back(cyc);
        rspv_cnt++;
      end
      if (psel) psel_cnt++;
      if (penable) pen_cnt++;
      if (psel && !psel_prev) psel_rise++;
      if (psel) pen_hist = {pen_hist[2:0], penable};
      psel_prev = psel;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic clear_mon();
    cfg_q.delete(); bus_q.delete(); acc_q.delete(); acc_edge_q.delete();
    rsp_q.delete(); rsp_edge_q.delete();
    psel_cnt = 0; pen_cnt = 0; rspv_cnt = 0; psel_rise = 0;
    pen_hist = '0; psel_prev = psel;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    do begin @(negedge pclk); #1; n++; end while (!cmd_ready && n < 100);
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_wait: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    if (w) last_wdata = d;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_q.size() < n && k < 1000) begin @(posedge pclk); k++; end
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (rsp_q.size() != n) begin
      errors++;
      $display("FAIL rsp_count: got %0d responses, required %0d", rsp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, required all 0",
               psel, penable, pwrite, paddr, pwdata);
    end
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b rdata=%h err=%b timeout=%b, required all 0",
               rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: cmd_ready=%b, required 0", cmd_ready);
    end
    preset = 1'b0;
    @(negedge pclk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge pclk); #1;
  endtask

  task automatic test_single_write();
    clear_mon();
    cfg_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h0});
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_rsp(1);
    checks++;
    if (psel_cnt != 2 || pen_cnt != 1) begin
      errors++; $display("FAIL write_phases: psel %0d penable %0d cycles, required 2 and 1", psel_cnt, pen_cnt);
    end
    checks++;
    if (rspv_cnt != 1) begin
      errors++; $display("FAIL write_pulse: rsp_valid high %0d cycles, required 1", rspv_cnt);
    end
    if (rsp_q.size() == 1 && acc_edge_q.size() == 1 && bus_q.size() == 1) begin
      checks++;
      if (rsp_edge_q[0] - acc_edge_q[0] != 2) begin
        errors++; $display("FAIL write_latency: %0d edges, required 2", rsp_edge_q[0] - acc_edge_q[0]);
      end
      checks++;
      if (rsp_q[0] !== '{rdata: 32'h0, err: 1'b0, timeout: 1'b0}) begin
        errors++; $display("FAIL write_rsp: got %h, required rdata 0 err 0 timeout 0", rsp_q[0]);
      end
      checks++;
      if (bus_q[0] !== '{w: 1'b1, a: 32'h10, d: 32'hDEAD_BEEF}) begin
        errors++; $display("FAIL write_bus: got %h, required write 0x10 data deadbeef", bus_q[0]);
      end
    end
  endtask

  task automatic test_wait_read();
    clear_mon();
    cfg_q.push_back('{waits: 3, err: 1'b0, rdata: 32'hDEAD_BEEF});
    send(1'b0, 32'h0000_0010, $urandom);
    wait_rsp(1);
    checks++;
    if (pen_cnt != 4 || psel_cnt != 5) begin
      errors++; $display("FAIL read_wait_phases: penable %0d psel %0d cycles, required 4 and 5", pen_cnt, psel_cnt);
    end
    if (rsp_q.size() == 1 && acc_edge_q.size() == 1 && bus_q.size() == 1) begin
      checks++;
      if (rsp_q[0] !== '{rdata: 32'hDEAD_BEEF, err: 1'b0, timeout: 1'b0}) begin
        errors++; $display("FAIL read_wait_rsp: got %h, required rdata deadbeef err 0", rsp_q[0]);
      end
      checks++;
      if (rsp_edge_q[0] - acc_edge_q[0] != 5) begin
        errors++; $display("FAIL read_wait_latency: %0d edges, required 5", rsp_edge_q[0] - acc_edge_q[0]);
      end
      checks++;
      if (bus_q[0] !== '{w: 1'b0, a: 32'h10, d: last_wdata}) begin
        errors++; $display("FAIL read_wait_bus: got %h, required read 0x10 pwdata %h", bus_q[0], last_wdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    cfg_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h0});
    cfg_q.push_back('{waits: 0, err: 1'b0, rdata: 32'h0});
    send(1'b1, 32'h4, $urandom);
    send(1'b1, 32'h8, $urandom);
    wait_rsp(2);
    checks++;
    if (psel_rise != 1 || psel_cnt != 4) begin
      errors++; $display("FAIL b2b_psel: %0d rises %0d cycles, required 1 and 4", psel_rise, psel_cnt);
    end
    checks++;
    if (pen_hist !== 4'b0101) begin
      errors++; $display("FAIL b2b_penable: pattern %b, required 0101", pen_hist);
    end
    if (rsp_edge_q.size() == 2 && bus_q.size() == 2) begin
      checks++;
      if (rsp_edge_q[1] - rsp_edge_q[0] != 2) begin
        errors++; $display("FAIL b2b_spacing: %0d cycles, required 2", rsp_edge_q[1] - rsp_edge_q[0]);
      end
      checks++;
      if (bus_q[0].a !== 32'h4 || bus_q[1].a !== 32'h8) begin
        errors++; $display("FAIL b2b_addr: got %h %h, required 4 8", bus_q[0].a, bus_q[1].a);
      end
    end
  endtask

  task automatic test_slverr();
    int w;
    w = $urandom_range(0, 3);
    clear_mon();
    cfg_q.push_back('{waits: w, err: 1'b1, rdata: $urandom});
    send(1'b0, 32'h0000_FFF0, $urandom);
    wait_rsp(1);
    if (rsp_q.size() == 1 && acc_edge_q.size() == 1) begin
      checks++;
      if (rsp_q[0].err !== 1'b1 || rsp_q[0].timeout !== 1'b0) begin
        errors++; $display("FAIL slverr_rsp: err=%b timeout=%b, required 1 0", rsp_q[0].err, rsp_q[0].timeout);
      end
      checks++;
      if (rsp_edge_q[0] - acc_edge_q[0] != 2 + w) begin
        errors++; $display("FAIL slverr_latency: %0d edges, required %0d", rsp_edge_q[0] - acc_edge_q[0], 2 + w);
      end
    end
  endtask

  task automatic test_timeout();
    clear_mon();
    cfg_q.push_back('{waits: 1000, err: 1'b0, rdata: 32'h0});
    send(1'b0, $urandom, $urandom);
    wait_rsp(1);
    checks++;
    if (pen_cnt != T + 1) begin
      errors++; $display("FAIL timeout_access: %0d ACCESS cycles, required %0d", pen_cnt, T + 1);
    end
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: psel=%b penable=%b, required 0 0", psel, penable);
    end
    if (rsp_q.size() == 1 && acc_edge_q.size() == 1) begin
      checks++;
      if (rsp_q[0] !== '{rdata: 32'h0, err: 1'b1, timeout: 1'b1}) begin
        errors++; $display("FAIL timeout_rsp: got %h, required rdata 0 err 1 timeout 1", rsp_q[0]);
      end
      checks++;
      if (rsp_edge_q[0] - acc_edge_q[0] != 2 + T) begin
        errors++; $display("FAIL timeout_latency: %0d edges, required %0d", rsp_edge_q[0] - acc_edge_q[0], 2 + T);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic [31:0] rd;
    clear_mon();
    cfg_q.push_back('{waits: 1000, err: 1'b0, rdata: 32'h0});
    send(1'b1, $urandom, $urandom);
    do begin @(negedge pclk); #1; k++; end while (!penable && k < 20);
    #2 preset = 1'b1;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || pwdata !== 32'h0) begin
      errors++; $display("FAIL reset_async: psel=%b penable=%b pwdata=%h, required 0 0 0", psel, penable, pwdata);
    end
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    last_wdata = '0;
    repeat (4) @(posedge pclk);
    #1;
    checks++;
    if (rspv_cnt != 0) begin
      errors++; $display("FAIL reset_no_rsp: %0d responses, required 0", rspv_cnt);
    end
    clear_mon();
    rd = $urandom;
    cfg_q.push_back('{waits: 1, err: 1'b0, rdata: rd});
    send(1'b0, 32'h20, $urandom);
    wait_rsp(1);
    if (rsp_q.size() == 1 && bus_q.size() == 1) begin
      checks++;
      if (rsp_q[0] !== '{rdata: rd, err: 1'b0, timeout: 1'b0}) begin
        errors++; $display("FAIL reset_recover: got %h, required rdata %h err 0", rsp_q[0], rd);
      end
      checks++;
      if (bus_q[0] !== '{w: 1'b0, a: 32'h20, d: 32'h0}) begin
        errors++; $display("FAIL reset_recover_bus: got %h, required read 0x20 pwdata 0", bus_q[0]);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 40;
    bus_t        cmds[N];
    cfg_t        cfgs[N];
    logic [31:0] exp_wd;
    apb_rsp_t    exp_rsp;
    logic        to;
    int          lat;
    exp_wd = last_wdata;
    clear_mon();
    for (int i = 0; i < N; i++) begin
      cmds[i] = '{w: 1'($urandom), a: $urandom & 32'hFFFF_FFFC, d: $urandom};
      cfgs[i] = '{waits: $urandom_range(0, T + 2), err: 1'($urandom), rdata: $urandom};
      cfg_q.push_back(cfgs[i]);
      send(cmds[i].w, cmds[i].a, cmds[i].d);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
      #1;
    end
    wait_rsp(N);
    checks++;
    if (bus_q.size() != N || acc_edge_q.size() != N) begin
      errors++; $display("FAIL rand_counts: %0d transfers %0d accepts, required %0d", bus_q.size(), acc_edge_q.size(), N);
    end
    for (int i = 0; i < N; i++) begin
      if (i < bus_q.size() && i < rsp_q.size() && i < acc_edge_q.size()) begin
        if (cmds[i].w) exp_wd = cmds[i].d;
        checks++;
        if (bus_q[i] !== '{w: cmds[i].w, a: cmds[i].a, d: exp_wd}) begin
          errors++; $display("FAIL rand_bus[%0d]: got %h, required %h", i, bus_q[i], {cmds[i].w, cmds[i].a, exp_wd});
        end
        to = cfgs[i].waits > T;
        exp_rsp.rdata   = (to || cmds[i].w) ? 32'h0 : cfgs[i].rdata;
        exp_rsp.err     = to ? 1'b1 : cfgs[i].err;
        exp_rsp.timeout = to;
        checks++;
        if (rsp_q[i] !== exp_rsp) begin
          errors++; $display("FAIL rand_rsp[%0d]: got %h, required %h", i, rsp_q[i], exp_rsp);
        end
        lat = 2 + ((cfgs[i].waits < T) ? cfgs[i].waits : T);
        checks++;
        if (rsp_edge_q[i] - acc_edge_q[i] != lat) begin
          errors++; $display("FAIL rand_latency[%0d]: %0d edges, required %0d", i, rsp_edge_q[i] - acc_edge_q[i], lat);
        end
      end
    end
  endtask

  initial begin
    #1 preset = 1'b1;
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
